// File: rtl/cfg_update_scheduler_pkg.sv
// Shared types and default widths for the sensor configuration path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cfg_update_scheduler_pkg;

    // Defaults shared with the I2C slave and the config transmitter
    localparam int CFG_N_REGS         = 8;
    localparam int CFG_ADDR_W         = 3;
    localparam int CFG_DATA_W         = 16;
    localparam int CFG_TIMEOUT_CYCLES = 4800;   // 100 us at 48 MHz
    localparam int CFG_UPD_CNT_W      = 8;

    // Update scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/cfg_update_scheduler_if.sv
// Bundles the I2C write port, window input, serializer handshake and status.
// Latency: n/a (wiring only).
// Backpressure: none; every strobe is a single-cycle pulse.
interface cfg_update_scheduler_if
    import cfg_update_scheduler_pkg::*;
#(
    parameter int ADDR_W = CFG_ADDR_W,
    parameter int DATA_W = CFG_DATA_W
) ();
    // I2C register interface side
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     force_all;
    // Frame decoder side
    logic                     cfg_window;
    // Config serializer side
    logic                     tx_start;
    logic                     tx_end;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]        rd_data;
    // Status
    logic                     busy;
    logic                     timeout_err;
    logic                     err_clr;
    logic [CFG_UPD_CNT_W-1:0] update_cnt;

    // Environment side: drives the inputs of the scheduler
    modport master (
        output wr_en, wr_addr, wr_data, force_all, cfg_window,
               tx_end, rd_en, rd_addr, err_clr,
        input  tx_start, rd_data, busy, timeout_err, update_cnt
    );

    // Scheduler side
    modport slave (
        input  wr_en, wr_addr, wr_data, force_all, cfg_window,
               tx_end, rd_en, rd_addr, err_clr,
        output tx_start, rd_data, busy, timeout_err, update_cnt
    );
endinterface

// File: rtl/cfg_update_scheduler_reg_bank.sv
// Shadow bank, active bank and dirty vector; commit copies shadow to active.
// Latency: writes/commit take effect next cycle; reads return 1 cycle after RD_EN.
// Backpressure: none; writes are always accepted, out-of-range ones dropped.
module cfg_reg_bank
    import cfg_update_scheduler_pkg::*;
#(
    parameter int N_REGS = CFG_N_REGS,
    parameter int ADDR_W = CFG_ADDR_W,
    parameter int DATA_W = CFG_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_set_all,
    input  logic              i_commit,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_any_dirty
);
    logic [DATA_W-1:0] r_shadow [N_REGS];
    logic [DATA_W-1:0] r_active [N_REGS];
    logic [N_REGS-1:0] r_dirty;
    logic [N_REGS-1:0] w_dirty_nxt;
    logic              w_wr_ok;
    logic              w_rd_in_range;

    // One extra bit so N_REGS == 2^ADDR_W does not truncate to zero
    assign w_wr_ok       = i_wr_en && ({1'b0, i_wr_addr} < (ADDR_W+1)'(N_REGS));
    assign w_rd_in_range = {1'b0, i_rd_addr} < (ADDR_W+1)'(N_REGS);
    assign o_any_dirty   = |r_dirty;

    // Shadow bank: written by the I2C side at any time
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_REGS; i++) r_shadow[i] <= '0;
        end else if (w_wr_ok) begin
            r_shadow[i_wr_addr] <= i_wr_data;
        end
    end

    // Active bank: takes the pre-write shadow contents on commit only
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_REGS; i++) r_active[i] <= '0;
        end else if (i_commit) begin
            for (int i = 0; i < N_REGS; i++) r_active[i] <= r_shadow[i];
        end
    end

    // Dirty next-state: commit clears, then writes and set-all override
    always_comb begin
        w_dirty_nxt = r_dirty;
        if (i_commit)  w_dirty_nxt = '0;
        if (w_wr_ok)   w_dirty_nxt[i_wr_addr] = 1'b1;
        if (i_set_all) w_dirty_nxt = '1;
    end

    // Dirty register; all set at reset so sensor defaults go out at the first window
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_dirty <= '1;
        else          r_dirty <= w_dirty_nxt;
    end

    // Registered read port; holds value when not strobed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= w_rd_in_range ? r_active[i_rd_addr] : '0;
        end
    end
endmodule

// File: rtl/cfg_update_scheduler.sv
// Commits dirty config at the start of a window, launches one transfer, supervises it.
// Latency: TX_START two cycles after the window edge; status updates one cycle after TX_END/timeout.
// Backpressure: window edges outside IDLE are dropped, never queued.
module cfg_update_scheduler
    import cfg_update_scheduler_pkg::*;
#(
    parameter int N_REGS         = CFG_N_REGS,
    parameter int ADDR_W         = CFG_ADDR_W,
    parameter int DATA_W         = CFG_DATA_W,
    parameter int TIMEOUT_CYCLES = CFG_TIMEOUT_CYCLES
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    cfg_update_scheduler_if.slave  if_cfg
);
    localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_cfg_prev;
    logic [CNT_W-1:0]         r_tmo_cnt;
    logic                     r_timeout_err;
    logic [CFG_UPD_CNT_W-1:0] r_update_cnt;
    logic                     w_win_rise;
    logic                     w_any_dirty;
    logic                     w_commit;
    logic                     w_tx_start;
    logic                     w_done;
    logic                     w_timeout;

    assign w_win_rise = if_cfg.cfg_window && !r_cfg_prev;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next-state and strobes; TX_END takes priority over timeout
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_tx_start  = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_rise && w_any_dirty) w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_tx_start  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (if_cfg.tx_end) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo_cnt == TMO_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Window edge detector
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cfg_prev <= 1'b0;
        else          r_cfg_prev <= if_cfg.cfg_window;
    end

    // Timeout counter: 1 in the first WAIT cycle, so it equals cycles since TX_START
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_SEND) begin
            r_tmo_cnt <= CNT_W'(1);
        end else if (r_state == ST_WAIT && r_tmo_cnt != TMO_MAX) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)            r_timeout_err <= 1'b0;
        else if (w_timeout)      r_timeout_err <= 1'b1;
        else if (if_cfg.err_clr) r_timeout_err <= 1'b0;
    end

    // Completed-transfer counter, wraps naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_update_cnt <= '0;
        else if (w_done) r_update_cnt <= r_update_cnt + CFG_UPD_CNT_W'(1);
    end

    // Timeout re-marks everything dirty so the next window retries
    cfg_reg_bank #(
        .N_REGS (N_REGS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_reg_bank (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_en     (if_cfg.wr_en),
        .i_wr_addr   (if_cfg.wr_addr),
        .i_wr_data   (if_cfg.wr_data),
        .i_set_all   (if_cfg.force_all || w_timeout),
        .i_commit    (w_commit),
        .i_rd_en     (if_cfg.rd_en),
        .i_rd_addr   (if_cfg.rd_addr),
        .o_rd_data   (if_cfg.rd_data),
        .o_any_dirty (w_any_dirty)
    );

    assign if_cfg.tx_start    = w_tx_start;
    assign if_cfg.busy        = (r_state != ST_IDLE);
    assign if_cfg.timeout_err = r_timeout_err;
    assign if_cfg.update_cnt  = r_update_cnt;
endmodule
